// File: rtl/nws_trace_sequencer_if.sv
// Byte-stream sink channel between the trace sequencer and a serial transmitter.
interface nws_trace_sequencer_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_in;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_in);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_in);
endinterface

// File: rtl/nws_trace_sequencer.sv
// Fetch trace FIFO plus line formatter streaming ASCII disassembly to a byte sink.
// Optional macro NWS_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to each line.
module nws_trace_sequencer #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                trace_en_in,
    input  logic                clear_in,
    input  logic                fetch_valid_in,
    input  logic [11:0]         fetch_addr_in,
    input  logic                fetch_bank_in,
    input  logic [9:0]          fetch_opcode_in,
    output logic [11:0]         dis_addr_o,
    output logic                dis_bank_o,
    output logic [9:0]          dis_opcode_o,
    input  logic [199:0]        dis_text_in,
    nws_trace_sequencer_if.master tx,
    output logic [LW-1:0]       fifo_level_o,
    output logic                overflow_o,
    output logic                busy_o
);

    localparam int AW = $clog2(DEPTH);
`ifdef NWS_TRACE_TIMESTAMP_EN
    localparam int EW   = 39;
    localparam int PLEN = 15;
`else
    localparam int EW   = 23;
    localparam int PLEN = 10;
`endif
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LATCH, S_PREFIX, S_TEXT, S_CR, S_LF
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q;
    logic [EW-1:0]   hold_q;
    logic [199:0]    text_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   push_entry;
    logic            push_req, push_ok, pop;
    logic [7:0]      cur_byte;
    logic [7:0]      tx_data;
    logic            tx_valid;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Entry layout: {[timestamp,] bank, addr, opcode}
    function automatic logic [7:0] prefix_byte(input logic [EW-1:0] e, input logic [4:0] i);
        logic [7:0] b;
        b = 8'h20;
        case (i)
            5'd0:  b = 8'h30 + {7'd0, e[22]};
            5'd1:  b = 8'h3A;
            5'd2:  b = hex_char(e[21:18]);
            5'd3:  b = hex_char(e[17:14]);
            5'd4:  b = hex_char(e[13:10]);
            5'd6:  b = hex_char({2'b00, e[9:8]});
            5'd7:  b = hex_char(e[7:4]);
            5'd8:  b = hex_char(e[3:0]);
`ifdef NWS_TRACE_TIMESTAMP_EN
            5'd10: b = hex_char(e[38:35]);
            5'd11: b = hex_char(e[34:31]);
            5'd12: b = hex_char(e[30:27]);
            5'd13: b = hex_char(e[26:23]);
`endif
            default: b = 8'h20;
        endcase
        return b;
    endfunction

`ifdef NWS_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    assign push_entry = {ts_q, fetch_bank_in, fetch_addr_in, fetch_opcode_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)     ts_q <= 16'h0000;
        else if (clear_in) ts_q <= 16'h0000;
        else               ts_q <= ts_q + 16'h0001;
    end
`else
    assign push_entry = {fetch_bank_in, fetch_addr_in, fetch_opcode_in};
`endif

    assign push_req = fetch_valid_in && trace_en_in && !clear_in;
    assign pop      = (state_q == S_LOAD) && !clear_in;
    assign push_ok  = push_req && ((level_q != FULL) || pop);
    assign cur_byte = text_q[{idx_q, 3'b000} +: 8];

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_IDLE:  if (level_q != '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_PREFIX;
                idx_d   = 5'd0;
            end
            S_PREFIX: begin
                tx_valid = 1'b1;
                tx_data  = prefix_byte(hold_q, idx_q);
                if (tx.tx_ready_in) begin
                    if (idx_q == 5'(PLEN - 1)) begin
                        state_d = S_TEXT;
                        idx_d   = 5'd24;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_TEXT: begin
                // NUL bytes are consumed in one cycle without touching the sink
                tx_valid = (cur_byte != 8'h00);
                tx_data  = cur_byte;
                if (cur_byte == 8'h00 || tx.tx_ready_in) begin
                    if (idx_q == 5'd0) state_d = S_CR;
                    else               idx_d = idx_q - 5'd1;
                end
            end
            S_CR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
                if (tx.tx_ready_in) state_d = S_LF;
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx.tx_ready_in) state_d = (level_q != '0) ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            text_q     <= '0;
        end else if (clear_in) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            text_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= mem_q[rd_ptr_q];
            end
            if (push_req && !push_ok) overflow_q <= 1'b1;
            // Disassembler has settled on hold_q for a full cycle by now
            if (state_q == S_LATCH) text_q <= dis_text_in;
        end
    end

    assign dis_bank_o    = hold_q[22];
    assign dis_addr_o    = hold_q[21:10];
    assign dis_opcode_o  = hold_q[9:0];
    assign tx.tx_data_o  = tx_data;
    assign tx.tx_valid_o = tx_valid;
    assign fifo_level_o  = level_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_nws_trace_sequencer.sv
// Self-checking bench for nws_trace_sequencer with a small in-bench disassembler.
module tb_nws_trace_sequencer;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trace_en = 1'b0;
    logic          clear = 1'b0;
    logic          fvalid = 1'b0;
    logic          fbank = 1'b0;
    logic [11:0]   faddr = '0;
    logic [9:0]    fop = '0;
    logic [11:0]   dis_addr;
    logic          dis_bank;
    logic [9:0]    dis_op;
    logic [199:0]  dis_text;
    logic [LW-1:0] level;
    logic          ovf;
    logic          busy;

    nws_trace_sequencer_if tx_if();

    nws_trace_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .trace_en_in(trace_en), .clear_in(clear),
        .fetch_valid_in(fvalid), .fetch_addr_in(faddr), .fetch_bank_in(fbank),
        .fetch_opcode_in(fop), .dis_addr_o(dis_addr), .dis_bank_o(dis_bank),
        .dis_opcode_o(dis_op), .dis_text_in(dis_text), .tx(tx_if),
        .fifo_level_o(level), .overflow_o(ovf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       stab_en = 1'b0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = '0;
    logic [15:0] tb_ts = '0;
    logic        rnd_on = 1'b0;

    typedef struct {
        logic        bank;
        logic [11:0] addr;
        logic [9:0]  op;
        string       pre;
        string       txt;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    // Toy disassembler: right-aligned text, NUL padding on the left
    function automatic logic [199:0] disasm(input logic b, input logic [9:0] o);
        logic [199:0] t;
        t = '0;
        if (o == 10'h000)              t[23:0] = "nop";
        else if (o == 10'h001)         t = '0;
        else if (o == 10'h002)         t[23:0] = {"a", 8'h00, "b"};
        else if (o[1:0] == 2'b11)      t[71:0] = {"go nc $", hexc(o[9:6]), hexc(o[5:2])};
        else t[63:0] = {"op", hexc({2'b00, o[9:8]}), hexc(o[7:4]), hexc(o[3:0]), " b", 8'h30 + {7'd0, b}};
        return t;
    endfunction

    assign dis_text = disasm(dis_bank, dis_op);

    function automatic string hexs(input logic [15:0] v, input int n);
        string s;
        s = "";
        for (int i = n - 1; i >= 0; i--) s = $sformatf("%s%c", s, hexc(v[i*4 +: 4]));
        return s;
    endfunction

    function automatic string model_pre(input logic b, input logic [11:0] a, input logic [9:0] o);
        return $sformatf("%0d:%s %s ", b, hexs({4'h0, a}, 3), hexs({6'h0, o}, 3));
    endfunction

    function automatic string model_text(input logic b, input logic [9:0] o);
        logic [199:0] t;
        string s;
        t = disasm(b, o);
        s = "";
        for (int k = 24; k >= 0; k--) if (t[k*8 +: 8] != 8'h00) s = $sformatf("%s%c", s, t[k*8 +: 8]);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_line(input string pre, input logic [15:0] ts, input string txt);
        string s;
`ifdef NWS_TRACE_TIMESTAMP_EN
        s = {pre, hexs(ts, 4), " ", txt};
`else
        s = {pre, txt};
        if (ts == 16'hFFFF) s = {pre, txt};
`endif
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the fetch for exactly one sampling edge
    task automatic push(input logic b, input logic [11:0] a, input logic [9:0] o,
                        input string pre, input string txt, input bit accept);
        fbank = b; faddr = a; fop = o; fvalid = 1'b1; trace_en = 1'b1;
        if (accept) add_line(pre, tb_ts, txt);
        @(posedge clk);
        #1;
        fvalid = 1'b0;
    endtask

    task automatic push_rand();
        logic b;
        logic [11:0] a;
        logic [9:0] o;
        b = 1'($urandom_range(0, 1));
        a = 12'($urandom);
        o = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 2)) : 10'($urandom);
        push(b, a, o, model_pre(b, a, o), model_text(b, o), 1'b1);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while ((busy || level != '0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_drain_timeout"}, 64'(c >= maxc), 64'd0);
    endtask

    task automatic compare(input string nm);
        chk({nm, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        if (!rst_n || clear) tb_ts <= '0;
        else                 tb_ts <= tb_ts + 16'd1;
    end

    always @(negedge clk) begin
        if (tx_if.tx_valid_o && tx_if.tx_ready_in) got_q.push_back(tx_if.tx_data_o);
        if (stab_en && pend) begin
            chk("hold_valid", 64'(tx_if.tx_valid_o), 64'd1);
            chk("hold_data", 64'(tx_if.tx_data_o), 64'(pend_data));
        end
        pend      <= tx_if.tx_valid_o && !tx_if.tx_ready_in;
        pend_data <= tx_if.tx_data_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tx_if.tx_ready_in = 1'b1;
        tbl[0] = '{1'b0, 12'h123, 10'h000, "0:123 000 ", "nop"};
        tbl[1] = '{1'b1, 12'hFFF, 10'h3FF, "1:FFF 3FF ", "go nc $FF"};
        tbl[2] = '{1'b0, 12'hABC, 10'h001, "0:ABC 001 ", ""};
        tbl[3] = '{1'b1, 12'h005, 10'h002, "1:005 002 ", "ab"};
        tbl[4] = '{1'b0, 12'h9E0, 10'h24A, "0:9E0 24A ", "op24A b0"};
        tbl[5] = '{1'b1, 12'h07D, 10'h1C3, "1:07D 1C3 ", "go nc $70"};

        // Reset state
        step(3);
        chk("rst_valid", 64'(tx_if.tx_valid_o), 64'd0);
        chk("rst_data", 64'(tx_if.tx_data_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dis", 64'({dis_bank, dis_addr, dis_op}), 64'd0);
        rst_n = 1'b1;
        step(1);

        // Capture disabled: fetch ignored
        fvalid = 1'b1;
        step(1);
        fvalid = 1'b0;
        step(1);
        chk("en_off_level", 64'(level), 64'd0);
        chk("en_off_busy", 64'(busy), 64'd0);

        // Table-driven lines with ready held high
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].bank, tbl[i].addr, tbl[i].op, tbl[i].pre, tbl[i].txt, 1'b1);
            chk($sformatf("t%0d_level_push", i), 64'(level), 64'd1);
            chk($sformatf("t%0d_busy_push", i), 64'(busy), 64'd0);
            cnt = 0;
            for (int k = 0; k < 100; k++) begin
                step(1);
                if (busy) begin
                    cnt++;
                    if (cnt == 1) chk($sformatf("t%0d_level_load", i), 64'(level), 64'd1);
                    if (cnt == 2) chk($sformatf("t%0d_level_pop", i), 64'(level), 64'd0);
                    if (cnt == 2) chk($sformatf("t%0d_dis", i), 64'({dis_bank, dis_addr, dis_op}),
                                      64'({tbl[i].bank, tbl[i].addr, tbl[i].op}));
                end else if (cnt > 0) begin
                    break;
                end
            end
            chk($sformatf("t%0d_line_cycles", i), 64'(cnt), 64'd39);
            compare($sformatf("t%0d", i));
        end

        // Random ready with random fetches
        stab_en = 1'b1;
        rnd_on  = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                tx_if.tx_ready_in = 1'($urandom_range(0, 1));
            end
        join_none
        for (int n = 0; n < 12; n++) begin
            step($urandom_range(1, 40));
            push_rand();
        end
        wait_idle(8000, "rnd");
        rnd_on = 1'b0;
        step(3);
        tx_if.tx_ready_in = 1'b1;
        compare("rnd");
        chk("rnd_ovf", 64'(ovf), 64'd0);

        // Fill to full with the sink stalled, then overflow
        tx_if.tx_ready_in = 1'b0;
        for (int n = 0; n < 17; n++) push_rand();
        chk("full_level", 64'(level), 64'd16);
        chk("full_ovf", 64'(ovf), 64'd0);
        push(1'b1, 12'h777, 10'h077, "", "", 1'b0);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_set", 64'(ovf), 64'd1);
        tx_if.tx_ready_in = 1'b1;
        wait_idle(3000, "full");
        compare("full");
        chk("ovf_sticky", 64'(ovf), 64'd1);
        stab_en = 1'b0;

        // Clear in the middle of the text field
        step(1);
        push(tbl[0].bank, tbl[0].addr, tbl[0].op, tbl[0].pre, tbl[0].txt, 1'b1);
        step(20);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_valid", 64'(tx_if.tx_valid_o), 64'd0);
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        got_q.delete();
        exp_q.delete();
        push(tbl[1].bank, tbl[1].addr, tbl[1].op, tbl[1].pre, tbl[1].txt, 1'b1);
        wait_idle(200, "clr");
        compare("clr");

        // Asynchronous reset while a prefix byte is stalled
        step(1);
        tx_if.tx_ready_in = 1'b0;
        push(tbl[4].bank, tbl[4].addr, tbl[4].op, tbl[4].pre, tbl[4].txt, 1'b0);
        step(5);
        chk("pre_rst_valid", 64'(tx_if.tx_valid_o), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(tx_if.tx_valid_o), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_dis", 64'({dis_bank, dis_addr, dis_op}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        tx_if.tx_ready_in = 1'b1;
        step(1);
        push(tbl[5].bank, tbl[5].addr, tbl[5].op, tbl[5].pre, tbl[5].txt, 1'b1);
        wait_idle(200, "post_rst");
        compare("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nws_trace_sequencer.md
Name: nws_trace_sequencer

Overview:
- Captures instruction fetches from the Woodstock core into a trace FIFO and drives the combinational opcode disassembler one entry at a time.
- Formats each entry as one ASCII line and streams it byte-wise over a valid/ready byte sink, e.g. a UART TX.
- Sits between the CPU fetch stage, the disassembler and the debug serial port.
- Decouples the CPU from a slow serial link.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- LW, 5, width of fifo_level_o; equals log2(DEPTH)+1.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- trace_en_in  input  1  capture enable
- clear_in  input  1  synchronous clear of FIFO, overflow_o and sequencer
- fetch_valid_in  input  1  one instruction fetched this cycle
- fetch_addr_in  input  12  fetch address
- fetch_bank_in  input  1  active bank
- fetch_opcode_in  input  10  fetched opcode
- dis_addr_o  output  12  address to disassembler
- dis_bank_o  output  1  bank to disassembler
- dis_opcode_o  output  10  opcode to disassembler
- dis_text_in  input  200  disassembler ASCII; 25 bytes, MSB byte first, NUL-padded on the left
- tx_data_o  output  8  byte to sink
- tx_valid_o  output  1  byte valid
- tx_ready_in  input  1  sink ready
- fifo_level_o  output  LW  entries held
- overflow_o  output  1  sticky: a fetch was dropped
- busy_o  output  1  sequencer not IDLE

Behaviour:
- Reset and clear:
  - All outputs are 0 at reset.
  - FIFO is empty and the state is IDLE.
  - clear_in acts like reset, but synchronously; any line in progress is aborted and tx_valid_o falls next cycle.
- Push:
  - Occurs when fetch_valid_in && trace_en_in, storing {bank, addr, opcode} (23 bits).
  - If the FIFO is full and there is no same-cycle pop, the entry is dropped and overflow_o is set.
  - A push and a pop in the same cycle at full are both accepted; the level is unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_level_o is registered and exact.
- States: IDLE, LOAD, LATCH, PREFIX, TEXT, CR, LF.
  - IDLE -> LOAD when the FIFO is non-empty.
  - LOAD: pops the head into the hold register; dis_* outputs are driven from the hold register, and are stable from LOAD until the next LOAD.
  - LATCH: registers dis_text_in into a 200-bit text register (one cycle of disassembler settling). Goes to PREFIX, with idx=0.
  - PREFIX emits 10 bytes, idx 0..9:
    - bank '0'/'1'
    - ':'
    - 3 uppercase hex digits of the address
    - ' '
    - 3 hex digits of the opcode (top digit 0-3)
    - ' '
  - TEXT scans text bytes 24 down to 0.
    - A NUL byte is skipped in one cycle with no emission.
    - A non-NUL byte is emitted.
    - After byte 0 -> CR.
  - CR emits 0x0D; LF emits 0x0A.
  - LF -> LOAD if the FIFO is non-empty, else IDLE.
- Emission handshake:
  - tx_valid_o rises with tx_data_o in the same cycle.
  - Both are held stable until tx_ready_in is high at a clock edge (transfer).
  - The next byte may be presented in the cycle after a transfer; there are no bubbles other than skipped NULs.
  - tx_valid_o never drops without a transfer, except on clear or reset.
- Hex digits are computed as 0-9 -> 0x30+n and A-F -> 0x37+n.
- trace_en_in falling stops pushes only; queued entries still drain.
- busy_o = (state != IDLE).
- An all-NUL text yields the prefix followed directly by CR LF.
- Minimum line time is 2 + 10 + 25 + 2 cycles with tx_ready_in held high.

Optional Feature:
- NWS_TRACE_TIMESTAMP_EN
- Defined:
  - A free-running 16-bit cycle counter (reset 0, wraps 0xFFFF -> 0) is captured with each push; FIFO width becomes 39 bits.
  - PREFIX grows to 15 bytes: the normal 10, then 4 hex digits of the timestamp and ' ' inserted before the text.
- Undefined: no counter; 10-byte prefix as above.

Test Plan:
- Disassembler instantiated in the bench. Push bank0, addr 0x123, opcode 0x000 -> bytes "0:123 000 nop" then 0D 0A (15 bytes). fifo_level_o goes 1 -> 0 at LOAD.
- Push bank1, addr 0xFFF, opcode 0x3FF -> "1:FFF 3FF go nc $FF" 0D 0A.
- tx_ready_in toggled randomly 0/1 -> tx_data_o stable while tx_valid_o && !tx_ready_in; byte stream identical to the ready-high case.
- With tx_ready_in=0, push 17 fetches (DEPTH=16): first entry popped at LOAD, 16 held -> fifo_level_o=16, overflow_o=0. A 18th push -> overflow_o=1, level 16. Release ready -> 17 complete lines in order.
- Assert clear_in mid-TEXT -> next cycle: tx_valid_o=0, level 0, overflow_o=0, busy_o=0. A subsequent push produces a full, correct line.
- Assert rst_n_in low asynchronously mid-PREFIX (no clock edge) -> tx_valid_o and busy_o go 0 immediately.
- Macro defined: push at counter 0x00A5 -> line begins "0:123 000 00A5 ".
